decoupled_queue: RTL and testbench
==================================

Name: decoupled_queue

Overview:
- Parametrised valid/ready FIFO that decouples a Master-side producer from a Slave-side consumer.
- Generalises the plain decoupled channel to configurable data width and buffer depth, plus a pipe mode.
- Inserted on any decoupled channel (e.g. AXI-style R/W reply paths) to break timing paths and absorb backpressure.
- Data is opaque. Callers pack struct payloads into DATA_W bits.

Parameters:
DATA_W, 32, payload width in bits (>=1)
DEPTH, 2, number of entries (>=1, any integer, not restricted to powers of 2)
PIPE, 0, 1 = a full queue accepts an enqueue in the same cycle as a dequeue

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
enq_valid  input  1  producer offers enq_data
enq_ready  output  1  queue accepts enq_data this cycle
enq_data  input  DATA_W  payload in
deq_valid  output  1  deq_data holds a valid entry
deq_ready  input  1  consumer takes deq_data this cycle
deq_data  output  DATA_W  payload out (head entry)
count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - count=0; read and write pointers=0.
  - deq_valid=0; enq_ready=1.
  - Storage contents are not reset. deq_data is don't-care while deq_valid=0.
- Transfers: enq fires when enq_valid&enq_ready; deq fires when deq_valid&deq_ready.
- Pointers: each pointer is $clog2(DEPTH) bits (min 1). It increments on its fire and wraps from DEPTH-1 to 0 explicitly.
- Count:
  - enq only: +1.
  - deq only: -1.
  - both, or neither: unchanged.
  - Never exceeds DEPTH and never underflows.
- Flags:
  - full = (count==DEPTH); empty = (count==0).
  - deq_valid = !empty. It is a registered-state function with no combinational path from deq_ready or enq_valid (without the optional feature).
  - enq_ready = !full. When PIPE=1: enq_ready = !full | deq_ready.
- Latency: an entry written in cycle N is visible at deq_data, with deq_valid=1, in cycle N+1.
- Ordering: strict FIFO. deq_data = mem[rd_ptr].
- Simultaneous enq and deq:
  - Non-full, non-empty: both pointers advance, count unchanged.
  - Full with PIPE=0: enq_ready=0, so only deq fires.
  - Full with PIPE=1 and deq_ready=1: both fire, count stays DEPTH.
  - Empty: only enq can fire.
- DEPTH=1: behaves as a single-entry register slice. With PIPE=1 it gives full throughput.
- Reset mid-operation: all entries are discarded immediately (asynchronous). Outputs return to reset values in the same cycle that rst is asserted.
- Protocol obligations:
  - Producer must hold enq_valid/enq_data stable until accepted.
  - The queue holds deq_valid/deq_data stable until dequeued.
- count reflects registered state only.

Optional Feature:
- Macro: DECOUPLED_QUEUE_FLOW_EN.
- Defined (flow-through when empty):
  - When empty and enq_valid=1: deq_valid=1 and deq_data=enq_data combinationally.
  - If deq_ready=1 in that cycle, the entry bypasses storage. No pointer moves and count stays 0.
  - If deq_ready=0, the entry is written normally and appears from storage in the next cycle.
  - Zero-latency path; adds an enq_valid->deq_valid combinational path.
- Undefined: no bypass. Minimum latency is 1 cycle, as in Behaviour.

Test Plan:
- Reset then idle, DEPTH=2: rst=1 mid-stream with count=2 -> same cycle deq_valid=0, enq_ready=1, count=0. No stale data appears after rst drops.
- Fill/drain, DEPTH=3, PIPE=0: enqueue 0xA1,0xA2,0xA3 with deq_ready=0 -> count=3, enq_ready=0. Then deq_ready=1 -> outputs 0xA1,0xA2,0xA3 on consecutive cycles, then deq_valid=0.
- Wrap-around, DEPTH=3: stream 10 words 0..9 with deq_ready toggling every cycle -> output order exactly 0..9. Pointers wrap 2->0 at least three times. count stays <=3.
- Full-and-simultaneous, DEPTH=2:
  - PIPE=0, full, enq_valid=1, deq_ready=1 -> only deq fires, count 2->1.
  - PIPE=1, same stimulus -> both fire, count stays 2.
- Throughput, DEPTH=2, PIPE=0: continuous enq_valid=1, deq_ready=1 for 100 cycles -> 1 transfer/cycle after first-word latency of 1 cycle. No bubbles.
- Flow, with DECOUPLED_QUEUE_FLOW_EN, empty:
  - enq 0x55 with deq_ready=1 -> deq_valid=1, deq_data=0x55 in the same cycle, count stays 0.
  - Without the macro, the same stimulus -> deq_valid=1 only in the next cycle.

Source files
------------

// File: rtl/decoupled_queue.sv
// decoupled_queue: parametrised valid/ready FIFO between a producer (enq side)
// and a consumer (deq side). DEPTH may be any integer >= 1; the pointers wrap
// explicitly at DEPTH-1, so non-power-of-two depths work.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high on that side. valid and its data stay stable until the transfer.
// ready may be high without valid and carries no obligation.
//
// Optional feature, selected by the macro DECOUPLED_QUEUE_FLOW_EN:
// - When the queue is empty, enq_data flows straight to deq_data in the same
//   cycle.
// - If the consumer takes the word in that cycle, storage is not touched.
// - Without the macro, deq_valid depends on registered state only.
module decoupled_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int PIPE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [DATA_W-1:0]          enq_data,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [DATA_W-1:0]          deq_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  occ;
  logic              full;
  logic              empty;
  logic              enq_fire;
  logic              deq_fire;
  logic              wr_en;
  logic              rd_en;

  assign full  = (occ == FULL_CNT);
  assign empty = (occ == '0);
  assign count = occ;

  // In pipe mode, a full queue still accepts a word because the head leaves in the same cycle.
  assign enq_ready = !full || ((PIPE != 0) && deq_ready);

  assign enq_fire = enq_valid && enq_ready;
  assign deq_fire = deq_valid && deq_ready;

`ifdef DECOUPLED_QUEUE_FLOW_EN
  logic bypass;

  // When empty, the incoming word is presented directly at the output.
  always_comb begin
    deq_valid = !empty || enq_valid;
    deq_data  = empty ? enq_data : mem[rd_ptr];
  end

  // A word consumed in its arrival cycle never touches storage.
  assign bypass = empty && enq_valid && deq_ready;
  assign wr_en  = enq_fire && !bypass;
  assign rd_en  = deq_fire && !bypass;
`else
  // The output is driven only by registered state, so there is no input-to-output timing path.
  always_comb begin
    deq_valid = !empty;
    deq_data  = mem[rd_ptr];
  end

  assign wr_en = enq_fire;
  assign rd_en = deq_fire;
`endif

  // Storage is deliberately not reset. Words are qualified by occupancy.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= enq_data;
    end
  end

  // Pointers wrap explicitly at DEPTH-1. Occupancy tracks net enq/deq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (wr_en && !rd_en) begin
        occ <= occ + 1'b1;
      end else if (rd_en && !wr_en) begin
        occ <= occ - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decoupled_queue.sv
// Bench for decoupled_queue. It runs three instances side by side:
//   [0] DEPTH=2 PIPE=0   [1] DEPTH=3 PIPE=0   [2] DEPTH=2 PIPE=1
// Each instance is checked every cycle against a queue-based reference model.
module tb_decoupled_queue;

  logic       clk;
  logic       rst;
  logic       enq_valid [3];
  logic       enq_ready [3];
  logic [7:0] enq_data  [3];
  logic       deq_valid [3];
  logic       deq_ready [3];
  logic [7:0] deq_data  [3];
  logic [1:0] count     [3];

  int dep [3];
  int pip [3];
  logic [7:0] exp_q [3][$];
  bit hold [3];
  int total = 0;
  int bad = 0;
  bit flow_en;

  decoupled_queue #(.DATA_W(8), .DEPTH(2), .PIPE(0)) u_q0 (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid[0]), .enq_ready(enq_ready[0]), .enq_data(enq_data[0]),
    .deq_valid(deq_valid[0]), .deq_ready(deq_ready[0]), .deq_data(deq_data[0]),
    .count(count[0])
  );

  decoupled_queue #(.DATA_W(8), .DEPTH(3), .PIPE(0)) u_q1 (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid[1]), .enq_ready(enq_ready[1]), .enq_data(enq_data[1]),
    .deq_valid(deq_valid[1]), .deq_ready(deq_ready[1]), .deq_data(deq_data[1]),
    .count(count[1])
  );

  decoupled_queue #(.DATA_W(8), .DEPTH(2), .PIPE(1)) u_q2 (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid[2]), .enq_ready(enq_ready[2]), .enq_data(enq_data[2]),
    .deq_valid(deq_valid[2]), .deq_ready(deq_ready[2]), .deq_data(deq_data[2]),
    .count(count[2])
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (observed running, required done)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      enq_valid[i] = 1'b0;
      enq_data[i]  = 8'h00;
      deq_ready[i] = 1'b0;
    end
  endtask

  // One clock cycle. Inputs are already set at the negedge. Outputs are checked
  // against the model, then the model applies the transfers the rules allow.
  task automatic step();
    bit ef [3];
    bit df [3];
    int n;
    bit ev;
    bit er;
    logic [7:0] head;
    #1;
    for (int i = 0; i < 3; i++) begin
      n = exp_q[i].size();
      ev = (n > 0);
      head = 8'h00;
      if (n > 0) head = exp_q[i][0];
      if (flow_en && n == 0 && enq_valid[i]) begin
        ev = 1'b1;
        head = enq_data[i];
      end
      er = (n < dep[i]) || (pip[i] != 0 && deq_ready[i]);
      chk($sformatf("count[%0d]", i), 32'(count[i]), 32'(n));
      chk($sformatf("deq_valid[%0d]", i), 32'(deq_valid[i]), 32'(ev));
      chk($sformatf("enq_ready[%0d]", i), 32'(enq_ready[i]), 32'(er));
      if (ev) chk($sformatf("deq_data[%0d]", i), 32'(deq_data[i]), 32'(head));
      ef[i] = enq_valid[i] && er;
      df[i] = deq_ready[i] && ev;
      hold[i] = enq_valid[i] && !er;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (ef[i]) exp_q[i].push_back(enq_data[i]);
      if (df[i]) void'(exp_q[i].pop_front());
    end
    @(negedge clk);
  endtask

  task automatic drain_all();
    idle_all();
    for (int i = 0; i < 3; i++) deq_ready[i] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    idle_all();
  endtask

  initial begin
    int sent;
    int xfers;
    int steps;
`ifdef DECOUPLED_QUEUE_FLOW_EN
    flow_en = 1'b1;
`else
    flow_en = 1'b0;
`endif
    dep = '{2, 3, 2};
    pip = '{0, 0, 1};
    for (int i = 0; i < 3; i++) hold[i] = 1'b0;
    idle_all();
    rst = 1'b1;

    // Reset values, sampled while rst is high
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_count[%0d]", i), 32'(count[i]), 32'd0);
      chk($sformatf("rst_deq_valid[%0d]", i), 32'(deq_valid[i]), 32'd0);
      chk($sformatf("rst_enq_ready[%0d]", i), 32'(enq_ready[i]), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;

    // Fill and drain, DEPTH=3
    for (int k = 0; k < 3; k++) begin
      enq_valid[1] = 1'b1;
      enq_data[1]  = 8'hA1 + 8'(k);
      step();
    end
    enq_valid[1] = 1'b0;
    chk("fill_count", 32'(count[1]), 32'd3);
    chk("fill_enq_ready", 32'(enq_ready[1]), 32'd0);
    deq_ready[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("drain_data", 32'(deq_data[1]), 32'hA1 + 32'(k));
      step();
    end
    chk("drain_empty", 32'(deq_valid[1]), 32'd0);
    idle_all();

    // Full with simultaneous enq/deq: PIPE=0 (inst 0) vs PIPE=1 (inst 2)
    for (int k = 0; k < 2; k++) begin
      enq_valid[0] = 1'b1; enq_data[0] = 8'h30 + 8'(k);
      enq_valid[2] = 1'b1; enq_data[2] = 8'h40 + 8'(k);
      step();
    end
    chk("full_count0", 32'(count[0]), 32'd2);
    chk("full_count2", 32'(count[2]), 32'd2);
    enq_data[0] = 8'h32; enq_data[2] = 8'h42;
    deq_ready[0] = 1'b1; deq_ready[2] = 1'b1;
    step();
    chk("simul_count_pipe0", 32'(count[0]), 32'd1);
    chk("simul_count_pipe1", 32'(count[2]), 32'd2);
    drain_all();

    // Reset mid-stream with the queue full
    enq_valid[0] = 1'b1; enq_data[0] = 8'h77;
    step();
    enq_data[0] = 8'h78;
    step();
    idle_all();
    chk("pre_rst_count", 32'(count[0]), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count[0]), 32'd0);
    chk("midrst_deq_valid", 32'(deq_valid[0]), 32'd0);
    chk("midrst_enq_ready", 32'(enq_ready[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      hold[i] = 1'b0;
    end
    deq_ready[0] = 1'b1;
    step();
    step();
    idle_all();

    // Wrap-around, DEPTH=3: words 0..9, deq_ready toggling every cycle
    sent = 0;
    steps = 0;
    while (sent < 10 && steps < 60) begin
      enq_valid[1] = 1'b1;
      enq_data[1]  = 8'(sent);
      deq_ready[1] = steps[0];
      step();
      if (!hold[1]) sent++;
      steps++;
    end
    chk("wrap_sent", 32'(sent), 32'd10);
    drain_all();

    // Throughput, DEPTH=2 PIPE=0: 100 cycles of continuous traffic
    xfers = 0;
    for (int k = 0; k < 100; k++) begin
      enq_valid[0] = 1'b1;
      enq_data[0]  = 8'(k);
      deq_ready[0] = 1'b1;
      #1;
      if (deq_valid[0]) xfers++;
      #1;
      step();
    end
    chk("throughput", 32'(xfers), flow_en ? 32'd100 : 32'd99);
    drain_all();

    // Flow-through stimulus on an empty queue
    enq_valid[0] = 1'b1; enq_data[0] = 8'h55; deq_ready[0] = 1'b1;
    #1;
    chk("flow_same_cycle_valid", 32'(deq_valid[0]), flow_en ? 32'd1 : 32'd0);
    step();
    enq_valid[0] = 1'b0;
    #1;
    chk("flow_next_cycle_valid", 32'(deq_valid[0]), flow_en ? 32'd0 : 32'd1);
    if (!flow_en) chk("flow_next_cycle_data", 32'(deq_data[0]), 32'h55);
    step();
    drain_all();

    // Randomized traffic on all three instances
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (!hold[i]) begin
          enq_valid[i] = 1'($urandom_range(0, 1));
          enq_data[i]  = 8'($urandom);
        end
        deq_ready[i] = 1'($urandom_range(0, 1));
      end
      step();
    end
    drain_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
